dma_burst_splitter: RTL and testbench
=====================================

Name: dma_burst_splitter

Overview:
- Successor to the single-channel DMA transmission splitter in the DMA read controller path.
- Accepts one host/device transfer job and emits a stream of PCIe-legal chunk requests to the TLP engine.
- Each chunk is bounded by Max_Read_Request_Size (reads), Max_Payload_Size (writes) and the host 4 KB boundary.
- Adds parametrised address and length widths, a valid/ready issue handshake, outstanding-read credit limiting, zero-length handling and abort.

Parameters:
ADDR_W, 64, width of host and device addresses
LEN_W, 32, width of job byte count
MAX_OUTST, 4, maximum read chunks issued but not yet completed (1..15)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
conf_valid  in  1  job offer
conf_ready  out  1  job accept; high only in IDLE
conf_addr_host  in  ADDR_W  job host start address
conf_addr_dev  in  ADDR_W  job device start address
conf_len  in  LEN_W  job byte count
conf_dir_write  in  1  1 = device-to-host write, 0 = read
conf_abort  in  1  stop issuing further chunks of the current job
pcie_dcommand  in  16  Device Control register; [7:5] MPS, [14:12] MRRS
req_valid  out  1  chunk request valid
req_ready  in  1  chunk accepted by TLP engine
req_addr_host  out  ADDR_W  chunk host address
req_addr_dev  out  ADDR_W  chunk device address
req_len  out  13  chunk bytes, 1..4096
req_dir_write  out  1  direction of the job
rd_cpl_done  in  1  pulse: one read chunk fully completed
job_done  out  1  one-cycle pulse at job end
job_aborted  out  1  valid with job_done; 1 if the job ended by abort
outst_cnt  out  4  current outstanding read chunks

Behaviour:
- Reset values: conf_ready=0 during reset, 1 in the first cycle after; req_valid=0, job_done=0, job_aborted=0, outst_cnt=0; state=IDLE.
- Size decode is latched at job accept and held for the whole job.
  - MRRS encodings 0..5 map to 128/256/512/1K/2K/4K bytes; 6 and 7 map to 128.
  - MPS encodings 0..3 map to 128/256/512/1K bytes; 4..7 map to 128.
- Accept: conf_valid & conf_ready. The job registers (addr_host, addr_dev, remaining, dir) are loaded and the FSM moves to ISSUE.
- Zero-length job: goes directly to DONE; no request is issued.
- Chunk length is computed combinationally from the registers as req_len = min(remaining, max_bytes, 4096 - addr_host[11:0]).
  - max_bytes is MPS for writes and MRRS for reads.
  - Compute in LEN_W+1 bits; the result is always 1..4096.
- ISSUE:
  - req_valid = 1, except for reads when outst_cnt == MAX_OUTST.
  - On req_valid & req_ready: both addresses += req_len, remaining -= req_len. Back-to-back accepts are allowed every cycle.
  - For reads, outst_cnt increments on each accepted chunk.
- Leaving ISSUE:
  - Accepting the last chunk (remaining == req_len) goes to DRAIN.
  - conf_abort while in ISSUE goes to DRAIN without issuing further, and sets the abort flag. If conf_abort coincides with an accept, that chunk is still counted as issued.
- DRAIN: wait for outst_cnt == 0. Writes pass through DRAIN in one cycle. On exit go to DONE.
- DONE: pulse job_done for one cycle, with job_aborted = abort flag. Return to IDLE next cycle; conf_ready rises in that cycle.
- outst_cnt update:
  - Simultaneous increment and rd_cpl_done: count is unchanged.
  - rd_cpl_done when the count is 0 is ignored; the count never underflows.
- Address arithmetic wraps modulo 2^ADDR_W. No error is flagged.
- conf_valid outside IDLE is ignored. conf_abort in IDLE or DRAIN is ignored.
- pcie_dcommand changes mid-job have no effect until the next accept.
- i_rst mid-job discards all state immediately. No job_done is produced.

Test Plan:
- Read, MRRS=512 (dcommand[14:12]=2), addr_host=0x1000, len=1300 → chunks 512, 512, 276 at 0x1000, 0x1200, 0x1400. With MAX_OUTST=4 there is no stall. job_done follows the third rd_cpl_done.
- Write, MPS=128, addr_host=0x0FC0, len=200 → chunks 64 (4K boundary), then 128, then 8. job_done 2 cycles after the last accept; outst_cnt stays 0.
- Read, MAX_OUTST=2, MRRS=128, len=512, no completions → exactly 2 accepts, then req_valid=0. Each rd_cpl_done pulse releases one further chunk.
- len=0 → no req_valid. job_done=1 and job_aborted=0 exactly 2 cycles after accept.
- Read len=4096, MRRS=128, abort asserted after 3 accepts → no further req_valid. job_done with job_aborted=1 after 3 completions.
- Simultaneous accept and rd_cpl_done with outst_cnt=1 → outst_cnt stays 1. A spurious rd_cpl_done at count 0 leaves it at 0.

Source files
------------

// File: rtl/dma_burst_splitter.sv
// Cuts one host/device transfer job into PCIe-legal chunk requests bounded by MRRS/MPS
// and the host 4 KB page, with outstanding-read credit limiting and abort.
//
// state   | meaning
// S_IDLE  | waiting for a job offer, conf_ready high
// S_ISSUE | presenting chunk requests to the TLP engine
// S_DRAIN | all chunks issued or aborted, waiting for read completions
// S_DONE  | one-cycle job_done pulse
module dma_burst_splitter #(
   parameter int ADDR_W    = 64,
   parameter int LEN_W     = 32,
   parameter int MAX_OUTST = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              conf_valid,
   output logic              conf_ready,
   input  logic [ADDR_W-1:0] conf_addr_host,
   input  logic [ADDR_W-1:0] conf_addr_dev,
   input  logic [LEN_W-1:0]  conf_len,
   input  logic              conf_dir_write,
   input  logic              conf_abort,
   input  logic [15:0]       pcie_dcommand,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [ADDR_W-1:0] req_addr_host,
   output logic [ADDR_W-1:0] req_addr_dev,
   output logic [12:0]       req_len,
   output logic              req_dir_write,
   input  logic              rd_cpl_done,
   output logic              job_done,
   output logic              job_aborted,
   output logic [3:0]        outst_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_host_q, addr_dev_q;
   logic [LEN_W-1:0]  remaining_q;
   logic [12:0]       max_bytes_q;
   logic              dir_q, abort_q;
   logic [3:0]        outst_q;

   logic [LEN_W:0]    rem_x, max_x, bnd_x, len_x;
   logic              conf_accept, accept, last_chunk, credit_ok, outst_inc, outst_dec;
   logic              unused_dcmd;

   function automatic logic [12:0] mrrs_bytes(input logic [2:0] enc);
      case (enc)
         3'd0:    mrrs_bytes = 13'd128;
         3'd1:    mrrs_bytes = 13'd256;
         3'd2:    mrrs_bytes = 13'd512;
         3'd3:    mrrs_bytes = 13'd1024;
         3'd4:    mrrs_bytes = 13'd2048;
         3'd5:    mrrs_bytes = 13'd4096;
         default: mrrs_bytes = 13'd128;
      endcase
   endfunction

   function automatic logic [12:0] mps_bytes(input logic [2:0] enc);
      case (enc)
         3'd0:    mps_bytes = 13'd128;
         3'd1:    mps_bytes = 13'd256;
         3'd2:    mps_bytes = 13'd512;
         3'd3:    mps_bytes = 13'd1024;
         default: mps_bytes = 13'd128;
      endcase
   endfunction

   assign unused_dcmd = ^{pcie_dcommand[15], pcie_dcommand[11:8], pcie_dcommand[4:0]};

   // Chunk = min(remaining, max payload/read size, bytes left in the current 4 KB page)
   always_comb begin
      rem_x = {1'b0, remaining_q};
      max_x = (LEN_W+1)'(max_bytes_q);
      bnd_x = (LEN_W+1)'(13'h1000 - {1'b0, addr_host_q[11:0]});
      len_x = rem_x;
      if (max_x < len_x) len_x = max_x;
      if (bnd_x < len_x) len_x = bnd_x;
   end

   assign conf_ready  = (state_q == S_IDLE) & ~i_rst;
   assign conf_accept = conf_valid & conf_ready;
   assign credit_ok   = dir_q | (outst_q != 4'(MAX_OUTST));
   assign req_valid   = (state_q == S_ISSUE) & (remaining_q != '0) & credit_ok;
   assign accept      = req_valid & req_ready;
   assign last_chunk  = (remaining_q == len_x[LEN_W-1:0]);
   assign outst_inc   = accept & ~dir_q;
   assign outst_dec   = rd_cpl_done & (outst_q != 4'd0);

   assign req_addr_host = addr_host_q;
   assign req_addr_dev  = addr_dev_q;
   assign req_len       = len_x[12:0];
   assign req_dir_write = dir_q;
   assign outst_cnt     = outst_q;

   always_comb begin
      state_d     = state_q;
      job_done    = 1'b0;
      job_aborted = 1'b0;
      case (state_q)
         S_IDLE:  if (conf_accept) state_d = S_ISSUE;
         S_ISSUE: begin
            if (remaining_q == '0)                    state_d = S_DONE;
            else if (conf_abort || (accept && last_chunk)) state_d = S_DRAIN;
         end
         S_DRAIN: if (outst_q == 4'd0) state_d = S_DONE;
         S_DONE: begin
            job_done    = 1'b1;
            job_aborted = abort_q;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         addr_host_q <= '0;
         addr_dev_q  <= '0;
         remaining_q <= '0;
         max_bytes_q <= 13'd128;
         dir_q       <= 1'b0;
         abort_q     <= 1'b0;
         outst_q     <= 4'd0;
      end else begin
         state_q <= state_d;
         if (conf_accept) begin
            addr_host_q <= conf_addr_host;
            addr_dev_q  <= conf_addr_dev;
            remaining_q <= conf_len;
            dir_q       <= conf_dir_write;
            abort_q     <= 1'b0;
            max_bytes_q <= conf_dir_write ? mps_bytes(pcie_dcommand[7:5])
                                          : mrrs_bytes(pcie_dcommand[14:12]);
         end
         if (accept) begin
            addr_host_q <= addr_host_q + ADDR_W'(len_x);
            addr_dev_q  <= addr_dev_q + ADDR_W'(len_x);
            remaining_q <= remaining_q - len_x[LEN_W-1:0];
         end
         if ((state_q == S_ISSUE) && conf_abort) abort_q <= 1'b1;
         case ({outst_inc, outst_dec})
            2'b10:   outst_q <= outst_q + 4'd1;
            2'b01:   outst_q <= outst_q - 4'd1;
            default: outst_q <= outst_q;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_burst_splitter.sv
// Bench for dma_burst_splitter: table of plan vectors, hand sequences for credit/reset
// corners, and random jobs checked against a chunk-list reference model.
module tb_dma_burst_splitter;
   localparam int AW   = 64;
   localparam int LW   = 32;
   localparam int MAXO = 4;

   logic i_clk = 1'b0;
   logic i_rst;

   logic          conf_valid, conf_ready, conf_dir_write, conf_abort;
   logic [AW-1:0] conf_addr_host, conf_addr_dev;
   logic [LW-1:0] conf_len;
   logic [15:0]   pcie_dcommand;
   logic          req_valid, req_ready, req_dir_write, rd_cpl_done, job_done, job_aborted;
   logic [AW-1:0] req_addr_host, req_addr_dev;
   logic [12:0]   req_len;
   logic [3:0]    outst_cnt;

   logic          b_conf_valid, b_conf_ready, b_conf_dir_write, b_conf_abort;
   logic [AW-1:0] b_conf_addr_host, b_conf_addr_dev;
   logic [LW-1:0] b_conf_len;
   logic [15:0]   b_pcie_dcommand;
   logic          b_req_valid, b_req_ready, b_req_dir_write, b_rd_cpl_done, b_job_done, b_job_aborted;
   logic [AW-1:0] b_req_addr_host, b_req_addr_dev;
   logic [12:0]   b_req_len;
   logic [3:0]    b_outst_cnt;

   always #5 i_clk = ~i_clk;

   dma_burst_splitter #(.ADDR_W(AW), .LEN_W(LW), .MAX_OUTST(MAXO)) u_dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .conf_valid(conf_valid), .conf_ready(conf_ready),
      .conf_addr_host(conf_addr_host), .conf_addr_dev(conf_addr_dev),
      .conf_len(conf_len), .conf_dir_write(conf_dir_write), .conf_abort(conf_abort),
      .pcie_dcommand(pcie_dcommand),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr_host(req_addr_host), .req_addr_dev(req_addr_dev),
      .req_len(req_len), .req_dir_write(req_dir_write),
      .rd_cpl_done(rd_cpl_done), .job_done(job_done), .job_aborted(job_aborted),
      .outst_cnt(outst_cnt)
   );

   dma_burst_splitter #(.ADDR_W(AW), .LEN_W(LW), .MAX_OUTST(2)) u_dut2 (
      .i_clk(i_clk), .i_rst(i_rst),
      .conf_valid(b_conf_valid), .conf_ready(b_conf_ready),
      .conf_addr_host(b_conf_addr_host), .conf_addr_dev(b_conf_addr_dev),
      .conf_len(b_conf_len), .conf_dir_write(b_conf_dir_write), .conf_abort(b_conf_abort),
      .pcie_dcommand(b_pcie_dcommand),
      .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_addr_host(b_req_addr_host), .req_addr_dev(b_req_addr_dev),
      .req_len(b_req_len), .req_dir_write(b_req_dir_write),
      .rd_cpl_done(b_rd_cpl_done), .job_done(b_job_done), .job_aborted(b_job_aborted),
      .outst_cnt(b_outst_cnt)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [63:0] host;
      logic [63:0] dev;
      int          len;
   } chunk_t;

   typedef struct {
      logic [63:0] host;
      logic [63:0] dev;
      int          len;
      bit          dir;
      logic [15:0] dcmd;
      int          abort_after;
      int          n;
      int          first;
      int          last;
      bit          ab;
   } tv_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   function automatic int mrrs_of(input logic [2:0] e);
      return (e <= 3'd5) ? (128 << e) : 128;
   endfunction

   function automatic int mps_of(input logic [2:0] e);
      return (e <= 3'd3) ? (128 << e) : 128;
   endfunction

   // Reference: the job is pre-cut into a chunk list; each cycle checks the DUT against it
   task automatic run_job(input logic [63:0] host, input logic [63:0] dev, input int len,
                          input bit dir, input logic [15:0] dcmd, input int abort_after,
                          input bit abort_blk, input int rdy_pct, input int cpl_pct,
                          input bit noise, output int n_acc, output int first_len,
                          output int last_len, output bit ab_seen);
      chunk_t      q[$];
      chunk_t      c;
      logic [63:0] h, d;
      int          rem, mx, outst, nacc_m, page_left;
      bit          issuing, zero, draining, done_now, nd, aborted, acc, exp_valid;
      bit          rdy, cpl, abt, fin, dec;
      mx = dir ? mps_of(dcmd[7:5]) : mrrs_of(dcmd[14:12]);
      h = host; d = dev; rem = len;
      while (rem > 0) begin
         page_left = 4096 - int'(h[11:0]);
         c.len  = (rem < mx) ? rem : mx;
         if (page_left < c.len) c.len = page_left;
         c.host = h; c.dev = d;
         q.push_back(c);
         h = h + 64'(c.len); d = d + 64'(c.len); rem = rem - c.len;
      end
      n_acc = 0; first_len = 0; last_len = 0; ab_seen = 0;
      conf_addr_host = host; conf_addr_dev = dev; conf_len = LW'(len);
      conf_dir_write = dir; pcie_dcommand = dcmd; conf_valid = 1'b1;
      conf_abort = 1'b0; req_ready = 1'b0; rd_cpl_done = 1'b0;
      @(negedge i_clk);
      chk("conf_ready_idle", conf_ready, 1);
      tick();
      conf_valid = 1'b0;
      issuing = 1; zero = (q.size() == 0); draining = 0; done_now = 0;
      aborted = 0; outst = 0; nacc_m = 0; fin = 0;
      for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
         exp_valid = issuing && (q.size() > 0) && (dir || outst < MAXO);
         abt = issuing && (nacc_m == abort_after);
         rdy = ($urandom_range(0, 99) < rdy_pct);
         if (abt && abort_blk) rdy = 0;
         cpl = ($urandom_range(0, 99) < cpl_pct);
         if (noise) begin
            if (!issuing) abt = ($urandom_range(0, 3) == 0);
            conf_valid     = 1'($urandom_range(0, 1));
            conf_addr_host = {$urandom, $urandom};
            conf_len       = LW'($urandom_range(0, 100));
            conf_dir_write = 1'($urandom_range(0, 1));
            pcie_dcommand  = 16'($urandom);
         end
         conf_abort = abt; req_ready = rdy; rd_cpl_done = cpl;
         @(negedge i_clk);
         chk("req_valid", req_valid, exp_valid);
         chk("outst_cnt", outst_cnt, outst);
         chk("job_done", job_done, done_now);
         chk("conf_ready_busy", conf_ready, 0);
         if (done_now) begin
            chk("job_aborted", job_aborted, aborted);
            ab_seen = job_aborted;
         end
         if (exp_valid && req_valid) begin
            chk("req_addr_host", req_addr_host, q[0].host);
            chk("req_addr_dev", req_addr_dev, q[0].dev);
            chk("req_len", req_len, q[0].len);
            chk("req_dir_write", req_dir_write, dir);
            if (rdy) begin
               n_acc++;
               if (n_acc == 1) first_len = int'(req_len);
               last_len = int'(req_len);
            end
         end
         tick();
         acc = exp_valid && rdy;
         nd  = 0;
         if (done_now) fin = 1;
         else if (issuing) begin
            if (abt) aborted = 1;
            if (zero) begin
               issuing = 0; nd = 1;
            end else begin
               if (acc) begin
                  void'(q.pop_front());
                  nacc_m++;
               end
               if (abt || q.size() == 0) begin
                  issuing = 0; draining = 1;
               end
            end
         end else if (draining && outst == 0) begin
            draining = 0; nd = 1;
         end
         dec   = cpl && (outst > 0);
         outst = outst + ((acc && !dir) ? 1 : 0) - (dec ? 1 : 0);
         done_now = nd;
      end
      chk("job_finished", fin, 1);
      conf_valid = 1'b0; conf_abort = 1'b0; req_ready = 1'b0; rd_cpl_done = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tv_t tv[8];
      int  n, f, l, acc2;
      bit  ab, seen;

      tv[0] = '{64'h1000, 64'h0, 1300, 0, 16'h2000, -1, 3, 512, 276, 0};
      tv[1] = '{64'h0FC0, 64'h500, 200, 1, 16'h0000, -1, 3, 64, 8, 0};
      tv[2] = '{64'h3000, 64'h0, 0, 0, 16'h2000, -1, 0, 0, 0, 0};
      tv[3] = '{64'h0, 64'h8000, 4096, 0, 16'h0000, 3, 3, 128, 128, 1};
      tv[4] = '{64'h0, 64'h0, 3000, 1, 16'h0060, -1, 3, 1024, 952, 0};
      tv[5] = '{64'h80, 64'h40, 300, 0, 16'h7000, -1, 3, 128, 44, 0};
      tv[6] = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h10, 40, 1, 16'h00A0, -1, 2, 16, 24, 0};
      tv[7] = '{64'h2000, 64'h0, 5000, 0, 16'h5000, -1, 2, 4096, 904, 0};

      i_rst = 1'b1;
      conf_valid = 0; conf_addr_host = '0; conf_addr_dev = '0; conf_len = '0;
      conf_dir_write = 0; conf_abort = 0; pcie_dcommand = '0; req_ready = 0; rd_cpl_done = 0;
      b_conf_valid = 0; b_conf_addr_host = '0; b_conf_addr_dev = '0; b_conf_len = '0;
      b_conf_dir_write = 0; b_conf_abort = 0; b_pcie_dcommand = '0; b_req_ready = 0;
      b_rd_cpl_done = 0;
      repeat (3) tick();
      @(negedge i_clk);
      chk("rst_conf_ready", conf_ready, 0);
      chk("rst_req_valid", req_valid, 0);
      chk("rst_job_done", job_done, 0);
      chk("rst_job_aborted", job_aborted, 0);
      chk("rst_outst", outst_cnt, 0);
      tick();
      i_rst = 1'b0;
      @(negedge i_clk);
      chk("rst_conf_ready_after", conf_ready, 1);
      chk("rst_b_conf_ready_after", b_conf_ready, 1);
      tick();

      for (int i = 0; i < 8; i++) begin
         run_job(tv[i].host, tv[i].dev, tv[i].len, tv[i].dir, tv[i].dcmd, tv[i].abort_after,
                 1'b1, 100, 100, 1'b0, n, f, l, ab);
         chk($sformatf("tv%0d_nchunks", i), n, tv[i].n);
         chk($sformatf("tv%0d_first_len", i), f, tv[i].first);
         chk($sformatf("tv%0d_last_len", i), l, tv[i].last);
         chk($sformatf("tv%0d_aborted", i), ab, tv[i].ab);
      end

      // Accept and completion in the same cycle, then a spurious completion at zero
      conf_addr_host = '0; conf_len = 384; conf_dir_write = 0; pcie_dcommand = '0;
      conf_valid = 1; tick(); conf_valid = 0;
      req_ready = 1; rd_cpl_done = 0;
      @(negedge i_clk); chk("sim_first_valid", req_valid, 1); tick();
      rd_cpl_done = 1;
      @(negedge i_clk); chk("sim_pre_outst", outst_cnt, 1); chk("sim_valid2", req_valid, 1);
      tick();
      req_ready = 0; rd_cpl_done = 0;
      @(negedge i_clk); chk("sim_inc_dec_outst", outst_cnt, 1); tick();
      req_ready = 1; rd_cpl_done = 1; seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge i_clk);
         if (job_done) seen = 1;
         tick();
      end
      chk("sim_job_done", seen, 1);
      req_ready = 0;
      @(negedge i_clk); chk("spur_pre_outst", outst_cnt, 0); tick();
      rd_cpl_done = 0;
      @(negedge i_clk); chk("spur_outst", outst_cnt, 0); tick();

      // Credit limit of two outstanding reads
      b_conf_addr_host = '0; b_conf_len = 512; b_conf_dir_write = 0; b_pcie_dcommand = '0;
      b_conf_valid = 1;
      @(negedge i_clk); chk("b_conf_ready", b_conf_ready, 1); tick();
      b_conf_valid = 0; b_req_ready = 1; acc2 = 0;
      repeat (6) begin
         @(negedge i_clk);
         if (b_req_valid) acc2++;
         tick();
      end
      chk("credit_accepts", acc2, 2);
      @(negedge i_clk);
      chk("credit_stall_valid", b_req_valid, 0);
      chk("credit_outst", b_outst_cnt, 2);
      b_rd_cpl_done = 1; tick(); b_rd_cpl_done = 0;
      @(negedge i_clk);
      chk("credit_release_valid", b_req_valid, 1);
      chk("credit_release_outst", b_outst_cnt, 1);
      acc2++; tick();
      @(negedge i_clk); chk("credit_restall_valid", b_req_valid, 0); tick();
      b_rd_cpl_done = 1; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge i_clk);
         if (b_req_valid) acc2++;
         if (b_job_done) seen = 1;
         tick();
      end
      chk("credit_job_done", seen, 1);
      chk("credit_total_chunks", acc2, 4);
      b_rd_cpl_done = 0; b_req_ready = 0;

      // Reset in the middle of a job
      conf_addr_host = '0; conf_len = 4096; conf_dir_write = 0; pcie_dcommand = '0;
      conf_valid = 1; tick(); conf_valid = 0; req_ready = 1;
      repeat (3) tick();
      @(negedge i_clk); chk("midjob_valid", req_valid, 1);
      i_rst = 1; tick();
      @(negedge i_clk);
      chk("midrst_req_valid", req_valid, 0);
      chk("midrst_outst", outst_cnt, 0);
      chk("midrst_conf_ready", conf_ready, 0);
      i_rst = 0; req_ready = 0; tick();
      for (int i = 0; i < 4; i++) begin
         @(negedge i_clk);
         chk("midrst_no_done", job_done, 0);
         chk("midrst_idle_ready", conf_ready, 1);
         tick();
      end

      // Random jobs against the chunk-list model
      for (int j = 0; j < 40; j++) begin
         logic [63:0] host;
         int          len, r, aa;
         bit          dir;
         host = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) host[11:0] = 12'hFFF - 12'($urandom_range(0, 200));
         r   = int'($urandom_range(0, 9));
         len = (r == 0) ? 0 : (r < 3) ? int'($urandom_range(1, 16)) : int'($urandom_range(1, 6000));
         dir = 1'($urandom_range(0, 1));
         aa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
         run_job(host, {$urandom, $urandom}, len, dir, 16'($urandom), aa,
                 1'($urandom_range(0, 1)), int'($urandom_range(30, 100)),
                 int'($urandom_range(10, 90)), 1'b1, n, f, l, ab);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
